// File: rtl/multu_seq_pkg.sv
// Shared function codes, FSM encoding and the shift-add step for the
// sequential unsigned multiplier and the ALU control that drives it.
package multu_seq_pkg;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DONE  = 6'b111111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  // Iteration count value on entry to the final shift-add step.
  localparam logic [5:0] ITER_LAST = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  // One shift-add step; the 33-bit upper sum keeps the carry in the shift.
  function automatic logic [63:0] shift_add(input logic [63:0] prod,
                                            input logic [31:0] mcand);
    logic [32:0] upper;
    if (prod[0]) begin
      upper = {1'b0, prod[63:32]} + {1'b0, mcand};
    end else begin
      upper = {1'b0, prod[63:32]};
    end
    return {upper, prod[31:1]};
  endfunction

endpackage

// File: rtl/multu_seq_hilo_reg.sv
// HI/LO product storage, written only on a commit, with the MFHI/MFLO read mux.
module hilo_reg
  import multu_seq_pkg::*;
#(
  parameter logic [5:0] MFHI = FN_MFHI,
  parameter logic [5:0] MFLO = FN_MFLO
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [63:0] wdata,
  input  logic [5:0]  Signal,
  output logic [31:0] dataOut
);

  logic [31:0] hi_r;
  logic [31:0] lo_r;

  // HI/LO storage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (we) begin
      hi_r <= wdata[63:32];
      lo_r <= wdata[31:0];
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Non-destructive read mux.
  always_comb begin
    dataOut = 32'd0;
    if (Signal == MFHI) begin
      dataOut = hi_r;
    end else if (Signal == MFLO) begin
      dataOut = lo_r;
    end else begin
      dataOut = 32'd0;
    end
  end

endmodule

// File: rtl/multu_seq.sv
// Sequential 32x32 unsigned shift-add multiplier: one MULTU code per
// iteration, DONE commits the product into HI/LO.
module multu_seq
  import multu_seq_pkg::*;
#(
  parameter logic [5:0] MULTU = FN_MULTU,
  parameter logic [5:0] DONE  = FN_DONE,
  parameter logic [5:0] MFHI  = FN_MFHI,
  parameter logic [5:0] MFLO  = FN_MFLO
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  state_t      state_r, state_s;
  logic [63:0] prod_r, prod_s;
  logic [31:0] mcand_r, mcand_s;
  logic [5:0]  cnt_r, cnt_s;
  logic        done_r;
  logic        commit_s;

  // FSM and datapath state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      prod_r  <= 64'd0;
      mcand_r <= 32'd0;
      cnt_r   <= 6'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      prod_r  <= prod_s;
      mcand_r <= mcand_s;
      cnt_r   <= cnt_s;
      done_r  <= commit_s;
    end
  end

  // Next-state, iteration and commit decode.
  always_comb begin
    state_s  = state_r;
    prod_s   = prod_r;
    mcand_s  = mcand_r;
    cnt_s    = cnt_r;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Signal == MULTU) begin
          // Operands are captured here only; RUN never looks at dataA/dataB.
          mcand_s = dataA;
          prod_s  = shift_add({32'd0, dataB}, dataA);
          cnt_s   = 6'd1;
          state_s = ST_RUN;
        end else begin
          cnt_s   = 6'd0;
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Signal == MULTU) begin
          prod_s = shift_add(prod_r, mcand_r);
          cnt_s  = cnt_r + 6'd1;
          if (cnt_r == ITER_LAST) begin
            state_s = ST_FULL;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          cnt_s   = 6'd0;
          state_s = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (Signal == DONE) begin
          commit_s = 1'b1;
          cnt_s    = 6'd0;
          state_s  = ST_IDLE;
        end else if (Signal == MULTU) begin
          state_s = ST_FULL;
        end else begin
          cnt_s   = 6'd0;
          state_s = ST_IDLE;
        end
      end
      default: begin
        cnt_s   = 6'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_r == ST_RUN);
  assign done = done_r;

  hilo_reg #(
    .MFHI (MFHI),
    .MFLO (MFLO)
  ) u_hilo (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit_s),
    .wdata   (prod_r),
    .Signal  (Signal),
    .dataOut (dataOut)
  );

endmodule

// File: tb/tb_multu_seq.sv
// Self-checking bench for multu_seq: directed table, corner sequences and
// randomized operands against a plain-arithmetic product model.
module tb_multu_seq;

  localparam logic [5:0] C_MULTU = 6'd25;
  localparam logic [5:0] C_DONE  = 6'b111111;
  localparam logic [5:0] C_MFHI  = 6'b010000;
  localparam logic [5:0] C_MFLO  = 6'b010010;
  localparam logic [5:0] C_ADD   = 6'b100000;
  localparam logic [5:0] C_SUB   = 6'b100010;

  logic        clk;
  logic        rst_n;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;
  int done_seen;
  int commits;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          extra;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[4];

  multu_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    Signal = C_MFHI;
    #1;
    hi = dataOut;
    Signal = C_MFLO;
    #1;
    lo = dataOut;
  endtask

  // Full operation: 32 MULTU edges, extra held MULTU edges, one DONE edge.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int extra,
                          output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    Signal = C_MULTU;
    dataA  = a;
    dataB  = b;
    tick();
    check("busy_after_load", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 32 + extra; i++) begin
      dataA = $urandom;
      dataB = $urandom;
      tick();
    end
    check("busy_in_full", {31'd0, busy}, 32'd0);
    Signal = C_DONE;
    tick();
    commits++;
    hi_m = p[63:32];
    lo_m = p[31:0];
    check("done_pulse", {31'd0, done}, 32'd1);
    read_hilo(hi, lo);
    check("model_hi", hi, hi_m);
    check("model_lo", lo, lo_m);
  endtask

  initial begin
    logic [31:0] hi, lo, a, b;
    vectors     = 0;
    miscompares = 0;
    done_seen   = 0;
    commits     = 0;
    hi_m        = 32'd0;
    lo_m        = 32'd0;

    tbl[0] = '{a: 32'd3,          b: 32'd5,          extra: 0, hi: 32'd0,          lo: 32'd15};
    tbl[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   extra: 3, hi: 32'hFFFFFFFE,   lo: 32'h00000001};
    tbl[2] = '{a: 32'd6,          b: 32'd7,          extra: 0, hi: 32'd0,          lo: 32'd42};
    tbl[3] = '{a: 32'h80000000,   b: 32'd4,          extra: 0, hi: 32'd2,          lo: 32'd0};

    // Reset state
    rst_n  = 1'b0;
    Signal = C_MFHI;
    dataA  = 32'd0;
    dataB  = 32'd0;
    #22;
    check("rst_hi", dataOut, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    #5;
    rst_n = 1'b1;
    tick();

    // Directed table; entries 2 and 3 run back-to-back straight after commit
    for (int i = 0; i < 4; i++) begin
      run_mult(tbl[i].a, tbl[i].b, tbl[i].extra, hi, lo);
      check($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
      check($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
      if (i != 2) begin
        tick();
        check($sformatf("tbl%0d_done_clear", i), {31'd0, done}, 32'd0);
      end
    end

    // DONE in IDLE is ignored
    Signal = C_DONE;
    tick();
    check("idle_done_nopulse", {31'd0, done}, 32'd0);
    read_hilo(hi, lo);
    check("idle_done_hi", hi, hi_m);
    check("idle_done_lo", lo, lo_m);

    // Abort mid-run: 10 MULTU then ADD keeps HI/LO
    Signal = C_MULTU;
    dataA  = 32'd1000;
    dataB  = 32'd1000;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    Signal = C_ADD;
    tick();
    check("abort_busy_after", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    check("abort_hi", hi, hi_m);
    check("abort_lo", lo, lo_m);

    // DONE during RUN aborts too
    Signal = C_MULTU;
    for (int i = 0; i < 5; i++) tick();
    Signal = C_DONE;
    tick();
    check("run_done_busy", {31'd0, busy}, 32'd0);
    check("run_done_nopulse", {31'd0, done}, 32'd0);

    // FULL with another code discards the product
    Signal = C_MULTU;
    for (int i = 0; i < 32; i++) tick();
    Signal = C_SUB;
    tick();
    Signal = C_DONE;
    tick();
    check("full_discard_nopulse", {31'd0, done}, 32'd0);
    read_hilo(hi, lo);
    check("full_discard_hi", hi, hi_m);
    check("full_discard_lo", lo, lo_m);

    // Asynchronous reset mid-clock at iteration 20
    Signal = C_MULTU;
    dataA  = 32'd100;
    dataB  = 32'd200;
    for (int i = 0; i < 20; i++) tick();
    Signal = C_MFLO;
    #2;
    rst_n = 1'b0;
    #1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_lo", dataOut, 32'd0);
    Signal = C_MFHI;
    #1;
    check("midrst_hi", dataOut, 32'd0);
    #7;
    rst_n = 1'b1;
    tick();
    run_mult(32'd12345, 32'd678, 0, hi, lo);
    check("post_rst_lo", lo, 32'd8369910);
    check("post_rst_hi", hi, 32'd0);
    tick();

    // Randomized operands against the product model
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'hFFFFFFFF;
      run_mult(a, b, int'($urandom_range(0, 2)), hi, lo);
      tick();
    end

    check("done_pulse_count", 32'(done_seen), 32'(commits));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
